mac_axi4lite_master: RTL and testbench

AXI4-Lite initiator that turns a simple single-outstanding command/response interface into AXI4-Lite read and write transactions. It is the other end of the accelerator's AXI4-Lite slave CSR port. Host-side logic, DMA sequencers and self-test blocks use it to program f1/f2/a1 and read result over the same bus the slave decodes. Only one transaction is in flight at a time.

---
 rtl/mac_axi4lite_master.sv | 205 ++++++++++++++++++++
 tb/tb_mac_axi4lite_master.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_axi4lite_master.sv
`default_nettype none
// ============================================================================
// Module      : mac_axi4lite_master
// Description : Single-outstanding command/response to AXI4-Lite initiator,
//               with a sticky per-phase watchdog flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_axi4lite_master #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      timeout_err,
    output logic [ADDR_WIDTH-1:0]     M_AWADDR,
    output logic                      M_AWVALID,
    input  logic                      M_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
    output logic                      M_WVALID,
    input  logic                      M_WREADY,
    input  logic [1:0]                M_BRESP,
    input  logic                      M_BVALID,
    output logic                      M_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_ARADDR,
    output logic                      M_ARVALID,
    input  logic                      M_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_RDATA,
    input  logic [1:0]                M_RRESP,
    input  logic                      M_RVALID,
    output logic                      M_RREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ALIGN_BITS = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << ALIGN_BITS) - 1);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic                    rspw_q, rspw_d;
    logic [CNT_W-1:0]        wdog_q, wdog_d;
    logic                    tout_q, tout_d;
    logic                    busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
            rspw_q    <= 1'b0;
            wdog_q    <= '0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            rspw_q    <= rspw_d;
            wdog_q    <= wdog_d;
            tout_q    <= tout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        rspw_d    = rspw_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr & ADDR_MASK;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently; leave once both are gone
                awvalid_d = awvalid_q && !M_AWREADY;
                wvalid_d  = wvalid_q && !M_WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (M_BVALID) begin
                    resp_d  = M_BRESP;
                    rdata_d = '0;
                    rspw_d  = 1'b1;
                    state_d = RSP;
                end
            end
            RD_REQ: begin
                if (M_ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (M_RVALID) begin
                    rdata_d = M_RDATA;
                    resp_d  = M_RRESP;
                    rspw_d  = 1'b0;
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                  (state_q == RD_REQ) || (state_q == RD_DATA);

    // Counter saturates at TIMEOUT so a long stall cannot wrap and re-arm
    always_comb begin
        wdog_d = wdog_q;
        tout_d = tout_q;
        if (state_d != state_q) begin
            wdog_d = '0;
        end else if (busy && (wdog_q != CNT_MAX)) begin
            wdog_d = wdog_q + 1'b1;
        end
        if ((TIMEOUT != 0) && busy && (wdog_d == CNT_MAX)) begin
            tout_d = 1'b1;
        end
    end

    assign cmd_ready   = (state_q == IDLE) && !rst;
    assign rsp_valid   = (state_q == RSP);
    assign rsp_write   = rspw_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;
    assign timeout_err = tout_q;
    assign M_AWADDR    = addr_q;
    assign M_AWVALID   = awvalid_q;
    assign M_WDATA     = wdata_q;
    assign M_WSTRB     = wstrb_q;
    assign M_WVALID    = wvalid_q;
    assign M_BREADY    = (state_q == WR_RESP);
    assign M_ARADDR    = addr_q;
    assign M_ARVALID   = arvalid_q;
    assign M_RREADY    = (state_q == RD_DATA);

endmodule
`default_nettype wire

// File: tb/tb_mac_axi4lite_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mac_axi4lite_master
// Description : Directed, table-driven bench with a cycle-stepped AXI slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_axi4lite_master;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          timeout_err;
    logic [AW-1:0] M_AWADDR, M_ARADDR;
    logic          M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
    logic [DW-1:0] M_WDATA, M_RDATA;
    logic [SW-1:0] M_WSTRB;
    logic [1:0]    M_BRESP, M_RRESP;
    logic          M_BVALID, M_BREADY, M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

    always #5 clk = ~clk;

    mac_axi4lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout_err(timeout_err),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    // Stall counts are cycles of READY low after VALID is seen; lat delays B/R
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        int            aw_st;
        int            w_st;
        int            ar_st;
        int            lat;
        logic [1:0]    resp;
        logic [DW-1:0] rdata;
        int            rr;
        logic [AW-1:0] exp_addr;
        int            exp_rsp_cyc;
    } vec_t;

    vec_t vecs[7];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic slave_idle();
        M_AWREADY = 1'b0; M_WREADY = 1'b0; M_ARREADY = 1'b0;
        M_BVALID = 1'b0; M_BRESP = 2'b00;
        M_RVALID = 1'b0; M_RRESP = 2'b00; M_RDATA = 32'hBAD0_BAD0;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        bit aw_done = 0, w_done = 0, ar_done = 0, b_done = 0, r_done = 0, fin = 0, rsp_bad = 0;
        int awc = 0, wc = 0, arc = 0, bwait = 0, rwait = 0;
        int aw_first = -1, w_first = -1, ar_first = -1, rsp_first = -1;
        int aw_cyc = 0, w_cyc = 0, ar_cyc = 0, b_rdy = 0, r_rdy = 0, held = 0, viol = 0;
        logic [AW-1:0] a_seen = '0;
        logic [DW-1:0] wd_seen = '0;
        logic [SW-1:0] ws_seen = '0;
        logic [DW-1:0] exp_rd;
        string tag;
        tag = $sformatf("v%0d", idx);
        exp_rd = v.wr ? '0 : v.rdata;
        @(negedge clk);
        slave_idle();
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_wstrb = v.wstrb; rsp_ready = 1'b0;
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (cmd_ready && !rsp_valid) viol++;
            // AW / W / AR: once seen, held until handshake, then gone
            if (M_AWVALID) begin
                aw_cyc++;
                if (aw_first < 0) begin aw_first = cyc; a_seen = M_AWADDR; end
                else if (M_AWADDR !== a_seen) viol++;
            end
            if (aw_done && M_AWVALID) viol++;
            if (aw_first >= 0 && !aw_done && !M_AWVALID) viol++;
            if (M_WVALID) begin
                w_cyc++;
                if (w_first < 0) begin w_first = cyc; wd_seen = M_WDATA; ws_seen = M_WSTRB; end
                else if (M_WDATA !== wd_seen || M_WSTRB !== ws_seen) viol++;
            end
            if (w_done && M_WVALID) viol++;
            if (w_first >= 0 && !w_done && !M_WVALID) viol++;
            if (M_ARVALID) begin
                ar_cyc++;
                if (ar_first < 0) begin ar_first = cyc; a_seen = M_ARADDR; end
                else if (M_ARADDR !== a_seen) viol++;
            end
            if (ar_done && M_ARVALID) viol++;
            if (ar_first >= 0 && !ar_done && !M_ARVALID) viol++;
            if (M_BREADY) b_rdy++;
            if (M_RREADY) r_rdy++;
            // B / R beats, using handshake state from earlier cycles only
            M_BVALID = 1'b0;
            if (aw_done && w_done && !b_done) begin
                if (bwait == v.lat) begin M_BVALID = 1'b1; M_BRESP = v.resp; end
                else bwait++;
            end
            if (M_BVALID && M_BREADY) b_done = 1;
            M_RVALID = 1'b0; M_RDATA = 32'hBAD0_BAD0;
            if (ar_done && !r_done) begin
                if (rwait == v.lat) begin M_RVALID = 1'b1; M_RDATA = v.rdata; M_RRESP = v.resp; end
                else rwait++;
            end
            if (M_RVALID && M_RREADY) r_done = 1;
            M_AWREADY = 1'b0;
            if (M_AWVALID && !aw_done) begin
                if (awc == v.aw_st) begin M_AWREADY = 1'b1; aw_done = 1; end else awc++;
            end
            M_WREADY = 1'b0;
            if (M_WVALID && !w_done) begin
                if (wc == v.w_st) begin M_WREADY = 1'b1; w_done = 1; end else wc++;
            end
            M_ARREADY = 1'b0;
            if (M_ARVALID && !ar_done) begin
                if (arc == v.ar_st) begin M_ARREADY = 1'b1; ar_done = 1; end else arc++;
            end
            rsp_ready = 1'b0;
            if (rsp_valid) begin
                if (rsp_first < 0) rsp_first = cyc;
                if (rsp_write !== v.wr || rsp_rdata !== exp_rd || rsp_resp !== v.resp) rsp_bad = 1;
                held++;
                if (held == v.rr + 1) begin rsp_ready = 1'b1; fin = 1; end
            end
        end
        check({tag, "_completed"}, fin, 1);
        @(negedge clk);
        rsp_ready = 1'b0;
        slave_idle();
        check({tag, "_idle_after"}, {rsp_valid, cmd_ready}, 2'b01);
        check({tag, "_addr"}, a_seen, v.exp_addr);
        check({tag, "_viol"}, viol, 0);
        check({tag, "_rsp_cycle"}, rsp_first, v.exp_rsp_cyc);
        check({tag, "_rsp_held"}, held, v.rr + 1);
        check({tag, "_rsp_fields"}, {rsp_bad, rsp_write, rsp_resp}, {1'b0, v.wr, v.resp});
        check({tag, "_rsp_rdata"}, rsp_rdata, exp_rd);
        check({tag, "_timeout_err"}, timeout_err, 0);
        if (v.wr) begin
            check({tag, "_aw_w_first"}, {aw_first[7:0], w_first[7:0]}, 16'h0101);
            check({tag, "_aw_w_cycles"}, {aw_cyc[7:0], w_cyc[7:0]}, {8'(v.aw_st + 1), 8'(v.w_st + 1)});
            check({tag, "_wpayload"}, {wd_seen, ws_seen}, {v.wdata, v.wstrb});
            check({tag, "_ready_cycles"}, {b_rdy[7:0], r_rdy[7:0]}, {8'(v.lat + 1), 8'd0});
            check({tag, "_no_ar"}, ar_first < 0, 1);
        end else begin
            check({tag, "_ar_first"}, ar_first, 1);
            check({tag, "_ar_cycles"}, ar_cyc, v.ar_st + 1);
            check({tag, "_ready_cycles"}, {b_rdy[7:0], r_rdy[7:0]}, {8'd0, 8'(v.lat + 1)});
            check({tag, "_no_aw_w"}, (aw_first < 0) && (w_first < 0), 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        //              wr    addr     wdata         wstrb aw w ar lat resp   rdata          rr exp_addr rsp_cyc
        vecs[0] = '{1'b1, 12'h004, 32'h3F80_0000, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0,          0, 12'h004, 3};
        vecs[1] = '{1'b0, 12'h00C, 32'h0,         4'h0, 0, 0, 5, 0, 2'b00, 32'h4040_0000, 0, 12'h00C, 8};
        vecs[2] = '{1'b1, 12'h010, 32'h1234_5678, 4'hF, 3, 0, 0, 0, 2'b00, 32'h0,          0, 12'h010, 6};
        vecs[3] = '{1'b1, 12'h014, 32'hCAFE_F00D, 4'hF, 0, 3, 0, 0, 2'b00, 32'h0,          0, 12'h014, 6};
        vecs[4] = '{1'b1, 12'h007, 32'h0000_00A5, 4'h1, 0, 0, 0, 0, 2'b10, 32'h0,          4, 12'h004, 3};
        vecs[5] = '{1'b0, 12'h021, 32'h0,         4'h0, 0, 0, 0, 2, 2'b11, 32'hDEAD_BEEF, 1, 12'h020, 5};
        vecs[6] = '{1'b1, 12'hFFE, 32'h5555_AAAA, 4'h3, 2, 2, 0, 1, 2'b01, 32'h0,          0, 12'hFFC, 6};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        slave_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 0);
        check("reset_valids", {M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY, rsp_valid, timeout_err}, 7'd0);
        check("reset_regs", {M_AWADDR, M_WDATA, rsp_rdata, rsp_resp}, '0);
        rst = 1'b0;
        #1 check("reset_release_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

        // Stray B/R beats while idle must be ignored
        @(negedge clk);
        M_BVALID = 1'b1; M_BRESP = 2'b10; M_RVALID = 1'b1; M_RDATA = 32'h7777_7777;
        #1 check("stray_ready", {M_BREADY, M_RREADY}, 2'b00);
        @(negedge clk);
        check("stray_no_rsp", {rsp_valid, cmd_ready}, 2'b01);
        slave_idle();

        // Watchdog: ARREADY never comes
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h030;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        check("wdog_before", {timeout_err, M_ARVALID}, 2'b01);
        @(negedge clk);
        check("wdog_set", {timeout_err, M_ARVALID}, 2'b11);
        check("wdog_araddr", M_ARADDR, 12'h030);
        repeat (3) @(negedge clk);
        check("wdog_sticky", {timeout_err, M_ARVALID}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        check("rst_outputs", {cmd_ready, M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY, rsp_valid, timeout_err}, 8'd0);
        check("rst_regs", {M_ARADDR, rsp_rdata, rsp_resp}, '0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready_after", {cmd_ready, timeout_err}, 2'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
